accu_alu_datapath: RTL and testbench
====================================

Name: accu_alu_datapath

Overview:
- 4-bit execution datapath of the nibble CPU: operand bus driver, ALU and accumulator register.
- The operand bus driver places the fetched 4-bit operand on the data bus.
- The ALU combines the data bus (B) with the accumulator (A) under a 3-bit function code {S2,S1,S0} and produces result, carry and zero.
- The accumulator captures the ALU result on a load enable; the Flags, output and RAM blocks consume the result, C and Z.

Parameters:
- WIDTH, 4, datapath width of accu, oprnd, bus and ALU result. Only 4 is required to be verified.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- enabled_Bus_driver1  input  1  when 1, oprnd drives the data bus.
- oprnd  input  4  operand nibble from Fetch.
- bus_in  input  4  value placed on the bus by other drivers (inputs, RAM, ALU driver) when enabled_Bus_driver1=0.
- Instruccion  input  3  ALU function code {S2,S1,S0}.
- enabled_Accumulator  input  1  accumulator load enable (LoadA).
- data_bus  output  4  resolved bus value: oprnd if enabled_Bus_driver1, else bus_in.
- Salida_ALU  output  4  combinational ALU result.
- C  output  1  combinational ALU carry flag.
- Z  output  1  combinational ALU zero flag.
- accu  output  4  accumulator register.

Behaviour:
- Clocking and reset:
  - One clock domain. Reset is synchronous and active-high: it is sampled on the rising edge of clock.
  - On reset, accu becomes 4'h0. Reset has priority over enabled_Accumulator.
  - Reset mid-operation clears accu on that edge; the combinational outputs then follow immediately from A=0.
- Bus driver:
  - data_bus = enabled_Bus_driver1 ? oprnd : bus_in. Purely combinational, zero latency.
  - The bus is a mux, not tri-state; it never outputs X or Z.
- ALU operands:
  - A = accu (register output), B = data_bus. Fully combinational.
- ALU function codes:
  - 000: Y = A; C = 0.
  - 001: Y = A - B, computed as A + ~B + 1; C = carry out of bit 3. C=1 means no borrow (A >= B unsigned). This code is used for the compare (CMP) instruction.
  - 010: Y = B; C = 0.
  - 011: Y = A + B; C = carry out of bit 3. The result wraps mod 16.
  - 100: Y = ~(A & B) (bitwise NAND); C = 0.
  - 101, 110, 111: Y = 4'h0; C = 0.
- Zero flag: Z = (Y == 4'h0) for every code, including 101-111, which therefore give Z=1.
- Accumulator update:
  - On a rising edge with reset=0 and enabled_Accumulator=1: accu <= Salida_ALU, evaluated with the pre-edge accu. A read-modify-write such as accu <= accu + bus completes in one cycle.
  - With enabled_Accumulator=0, accu holds its value.
- Latency:
  - data_bus, Salida_ALU, C and Z settle in the same cycle.
  - The new accu value is visible one cycle after the load edge.
- Widths: all arithmetic is 5-bit internally. Bit 4 is C (for 001 and 011 only); bits 3:0 are Y.

Test Plan:
- Reset: drive reset=1 for one edge with enabled_Accumulator=1 and Salida_ALU=4'h9 -> accu=0. Then code 000 -> Y=0, Z=1, C=0.
- Load through the bus: enabled_Bus_driver1=1, oprnd=4'h7, code 010, enabled_Accumulator=1, one edge -> data_bus=7, accu=7, Z=0. Drop the enable -> accu stays 7 for 3 cycles while oprnd changes.
- Add with carry: accu=9, oprnd=8, code 011 -> Y=4'h1, C=1, Z=0. After a load edge, accu=1. Case accu=8, oprnd=8 -> Y=0, C=1, Z=1.
- Compare/subtract: accu=5, B=5, code 001 -> Y=0, C=1, Z=1. accu=3, B=5 -> Y=4'hE, C=0, Z=0. accu=5, B=3 -> Y=2, C=1.
- NAND and undefined codes: accu=4'hF, B=4'hF, code 100 -> Y=0, Z=1, C=0. accu=4'hA, B=4'h6 -> Y=4'hD. Codes 101/110/111 with any inputs -> Y=0, C=0, Z=1.
- Bus source select: enabled_Bus_driver1=0, bus_in=4'h3, oprnd=4'hC -> data_bus=3. Toggle the enable to 1 -> data_bus=C in the same cycle. Assert reset and enabled_Accumulator together -> accu=0 (reset wins).

Source files
------------

// File: rtl/accu_alu_datapath_if.sv
// Signal bundle between the nibble CPU control/fetch logic and the execution
// datapath: operand sources, ALU function code and load enable going in,
// resolved bus, ALU result, flags and accumulator coming out.
interface accu_alu_datapath_if #(
   parameter int WIDTH = 4
);
   logic             enabled_Bus_driver1;
   logic [WIDTH-1:0] oprnd;
   logic [WIDTH-1:0] bus_in;
   logic [2:0]       Instruccion;
   logic             enabled_Accumulator;
   logic [WIDTH-1:0] data_bus;
   logic [WIDTH-1:0] Salida_ALU;
   logic             C;
   logic             Z;
   logic [WIDTH-1:0] accu;

   // Control side: drives operands and controls, observes the datapath.
   modport master (
      output enabled_Bus_driver1, oprnd, bus_in, Instruccion, enabled_Accumulator,
      input  data_bus, Salida_ALU, C, Z, accu
   );

   // Datapath side.
   modport slave (
      input  enabled_Bus_driver1, oprnd, bus_in, Instruccion, enabled_Accumulator,
      output data_bus, Salida_ALU, C, Z, accu
   );
endinterface

// File: rtl/accu_alu_datapath.sv
// Execution datapath of the nibble CPU: operand bus driver (mux), ALU and
// accumulator. The bus and ALU are purely combinational; only the
// accumulator holds state.
module accu_alu_datapath #(
   parameter int WIDTH = 4
) (
   input logic                clock,
   input logic                reset,
   accu_alu_datapath_if.slave dp
);

   // ALU function codes {S2,S1,S0}; codes 101..111 are unused and yield zero.
   typedef enum logic [2:0] {
      ALU_PASS_A = 3'b000,
      ALU_SUB    = 3'b001,
      ALU_PASS_B = 3'b010,
      ALU_ADD    = 3'b011,
      ALU_NAND   = 3'b100
   } alu_op_e;

   localparam logic [WIDTH:0] ONE = (WIDTH+1)'(1);

   logic [WIDTH-1:0] accu_reg;
   logic [WIDTH-1:0] bus_value;
   logic [WIDTH:0]   alu_wide;   // bit WIDTH is the carry, low bits are Y

   // Bus driver: a plain mux so the bus is never left floating.
   assign bus_value = dp.enabled_Bus_driver1 ? dp.oprnd : dp.bus_in;

   // ALU: all arithmetic is one bit wider so the carry falls out of the top bit.
   always_comb begin
      // NOTE: default assignment first so every path writes alu_wide and no latch is inferred.
      alu_wide = '0;
      case (alu_op_e'(dp.Instruccion))
         ALU_PASS_A: alu_wide = {1'b0, accu_reg};
         // Subtract as A + ~B + 1; carry set means no borrow (A >= B).
         ALU_SUB:    alu_wide = {1'b0, accu_reg} + {1'b0, ~bus_value} + ONE;
         ALU_PASS_B: alu_wide = {1'b0, bus_value};
         ALU_ADD:    alu_wide = {1'b0, accu_reg} + {1'b0, bus_value};
         ALU_NAND:   alu_wide = {1'b0, ~(accu_reg & bus_value)};
         default:    alu_wide = '0;
      endcase
   end

   // Accumulator: synchronous reset has priority over the load enable.
   always_ff @(posedge clock) begin
      // NOTE: non-blocking assignment so the ALU sees the pre-edge accumulator.
      if (reset)
         accu_reg <= '0;
      else if (dp.enabled_Accumulator)
         accu_reg <= alu_wide[WIDTH-1:0];
   end

   assign dp.data_bus   = bus_value;
   assign dp.Salida_ALU = alu_wide[WIDTH-1:0];
   assign dp.C          = alu_wide[WIDTH];
   assign dp.Z          = (alu_wide[WIDTH-1:0] == '0);
   assign dp.accu       = accu_reg;

endmodule

// File: tb/tb_accu_alu_datapath.sv
// Directed bench for accu_alu_datapath. Each vector is applied just after a
// rising edge and its hand-computed expectation is queued; a monitor pops and
// compares on the following falling edge, before the next load edge.
module tb_accu_alu_datapath;

   logic clock = 1'b0;
   logic reset;

   accu_alu_datapath_if #(.WIDTH(4)) dp ();

   accu_alu_datapath #(.WIDTH(4)) dut (
      .clock (clock),
      .reset (reset),
      .dp    (dp.slave)
   );

   always #5 clock = ~clock;

   typedef struct {
      string      name;
      logic [3:0] bus;
      logic [3:0] y;
      logic       c;
      logic       z;
      logic [3:0] acc;
      bit         chk_alu;
      bit         chk_acc;
   } exp_t;

   exp_t sb[$];
   int   n_vectors     = 0;
   int   n_miscompares = 0;

   task automatic check(input string name, input string field,
                        input logic [3:0] actual, input logic [3:0] expected);
      if (actual !== expected) begin
         n_miscompares++;
         $display("FAIL %s.%s: got %h, expected %h", name, field, actual, expected);
      end
   endtask

   // Apply one vector and queue what the datapath must show this cycle
   // (accu is the value before the coming edge).
   task automatic vec(input string name, input logic rst, input logic en_bus,
                      input logic [3:0] opr, input logic [3:0] bin,
                      input logic [2:0] op, input logic load,
                      input logic [3:0] e_bus, input logic [3:0] e_y,
                      input logic e_c, input logic e_z, input logic [3:0] e_acc,
                      input bit chk_alu, input bit chk_acc);
      exp_t e;
      reset                  = rst;
      dp.enabled_Bus_driver1 = en_bus;
      dp.oprnd               = opr;
      dp.bus_in              = bin;
      dp.Instruccion         = op;
      dp.enabled_Accumulator = load;
      e.name    = name;
      e.bus     = e_bus;
      e.y       = e_y;
      e.c       = e_c;
      e.z       = e_z;
      e.acc     = e_acc;
      e.chk_alu = chk_alu;
      e.chk_acc = chk_acc;
      sb.push_back(e);
      @(posedge clock);
      #1;
   endtask

   // Monitor: outputs are continuously presented, so compare once per cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            n_vectors++;
            check(e.name, "data_bus", dp.data_bus, e.bus);
            if (e.chk_alu) begin
               check(e.name, "Y", dp.Salida_ALU, e.y);
               check(e.name, "C", {3'b0, dp.C}, {3'b0, e.c});
               check(e.name, "Z", {3'b0, dp.Z}, {3'b0, e.z});
            end
            if (e.chk_acc)
               check(e.name, "accu", dp.accu, e.acc);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset                  = 1'b1;
      dp.enabled_Bus_driver1 = 1'b0;
      dp.oprnd               = 4'h0;
      dp.bus_in              = 4'h0;
      dp.Instruccion         = 3'b000;
      dp.enabled_Accumulator = 1'b0;
      @(posedge clock);
      #1;

      //   name          rst en  opr   bin   op      ld   bus   Y     C     Z     accu  alu acc
      // Reset with load enabled and Y=9 pending; accu unknown before it.
      vec("rst_load",   1, 1, 4'h9, 4'h0, 3'b010, 1, 4'h9, 4'h9, 1'b0, 1'b0, 4'h0, 0, 0);
      vec("rst_a0",     0, 1, 4'h9, 4'h0, 3'b000, 0, 4'h9, 4'h0, 1'b0, 1'b1, 4'h0, 1, 1);
      // Load 7 through the bus, then hold for three cycles while oprnd changes.
      vec("load7",      0, 1, 4'h7, 4'h0, 3'b010, 1, 4'h7, 4'h7, 1'b0, 1'b0, 4'h0, 1, 1);
      vec("hold7_a",    0, 1, 4'h3, 4'h0, 3'b000, 0, 4'h3, 4'h7, 1'b0, 1'b0, 4'h7, 1, 1);
      vec("hold7_b",    0, 1, 4'hC, 4'h0, 3'b000, 0, 4'hC, 4'h7, 1'b0, 1'b0, 4'h7, 1, 1);
      vec("hold7_c",    0, 1, 4'h1, 4'h0, 3'b010, 0, 4'h1, 4'h1, 1'b0, 1'b0, 4'h7, 1, 1);
      // Add with carry: 9 + 8 = 0x11 -> Y=1, C=1; accumulate and read back.
      vec("load9",      0, 1, 4'h9, 4'h0, 3'b010, 1, 4'h9, 4'h9, 1'b0, 1'b0, 4'h7, 1, 1);
      vec("add_9p8",    0, 1, 4'h8, 4'h0, 3'b011, 1, 4'h8, 4'h1, 1'b1, 1'b0, 4'h9, 1, 1);
      vec("add_after",  0, 1, 4'h0, 4'h0, 3'b000, 0, 4'h0, 4'h1, 1'b0, 1'b0, 4'h1, 1, 1);
      vec("load8",      0, 1, 4'h8, 4'h0, 3'b010, 1, 4'h8, 4'h8, 1'b0, 1'b0, 4'h1, 1, 1);
      vec("add_8p8",    0, 1, 4'h8, 4'h0, 3'b011, 0, 4'h8, 4'h0, 1'b1, 1'b1, 4'h8, 1, 1);
      // Compare/subtract.
      vec("load5",      0, 1, 4'h5, 4'h0, 3'b010, 1, 4'h5, 4'h5, 1'b0, 1'b0, 4'h8, 1, 1);
      vec("cmp_5m5",    0, 1, 4'h5, 4'h0, 3'b001, 0, 4'h5, 4'h0, 1'b1, 1'b1, 4'h5, 1, 1);
      vec("cmp_5m3",    0, 1, 4'h3, 4'h0, 3'b001, 0, 4'h3, 4'h2, 1'b1, 1'b0, 4'h5, 1, 1);
      vec("load3",      0, 1, 4'h3, 4'h0, 3'b010, 1, 4'h3, 4'h3, 1'b0, 1'b0, 4'h5, 1, 1);
      vec("cmp_3m5",    0, 1, 4'h5, 4'h0, 3'b001, 0, 4'h5, 4'hE, 1'b0, 1'b0, 4'h3, 1, 1);
      // NAND.
      vec("loadF",      0, 1, 4'hF, 4'h0, 3'b010, 1, 4'hF, 4'hF, 1'b0, 1'b0, 4'h3, 1, 1);
      vec("nand_ff",    0, 1, 4'hF, 4'h0, 3'b100, 0, 4'hF, 4'h0, 1'b0, 1'b1, 4'hF, 1, 1);
      vec("loadA",      0, 1, 4'hA, 4'h0, 3'b010, 1, 4'hA, 4'hA, 1'b0, 1'b0, 4'hF, 1, 1);
      vec("nand_a6",    0, 1, 4'h6, 4'h0, 3'b100, 0, 4'h6, 4'hD, 1'b0, 1'b0, 4'hA, 1, 1);
      // Unused codes give Y=0, Z=1; the last one also loads that zero.
      vec("op101",      0, 1, 4'h7, 4'h0, 3'b101, 0, 4'h7, 4'h0, 1'b0, 1'b1, 4'hA, 1, 1);
      vec("op110",      0, 1, 4'hF, 4'h0, 3'b110, 0, 4'hF, 4'h0, 1'b0, 1'b1, 4'hA, 1, 1);
      vec("op111_ld",   0, 1, 4'h5, 4'h0, 3'b111, 1, 4'h5, 4'h0, 1'b0, 1'b1, 4'hA, 1, 1);
      // Bus source select, switching the enable between adjacent cycles.
      vec("bus_in_sel", 0, 0, 4'hC, 4'h3, 3'b010, 1, 4'h3, 4'h3, 1'b0, 1'b0, 4'h0, 1, 1);
      vec("oprnd_sel",  0, 1, 4'hC, 4'h3, 3'b010, 0, 4'hC, 4'hC, 1'b0, 1'b0, 4'h3, 1, 1);
      vec("add_rmw",    0, 1, 4'h4, 4'h3, 3'b011, 1, 4'h4, 4'h7, 1'b0, 1'b0, 4'h3, 1, 1);
      // Reset together with load: reset wins.
      vec("rst_wins",   1, 1, 4'h9, 4'h3, 3'b010, 1, 4'h9, 4'h9, 1'b0, 1'b0, 4'h7, 1, 1);
      vec("after_rst",  0, 1, 4'h9, 4'h3, 3'b000, 0, 4'h9, 4'h0, 1'b0, 1'b1, 4'h0, 1, 1);

      // Give the monitor a bounded number of cycles to drain the scoreboard.
      for (int i = 0; i < 10 && sb.size() > 0; i++)
         @(posedge clock);
      if (sb.size() > 0) begin
         n_miscompares++;
         $display("FAIL drain: %0d vectors left unchecked, expected 0", sb.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
      $finish;
   end

endmodule
